cpu_spm_be_ctrl: RTL and testbench

//  Parametrised dual-port scratch pad memory for the CPU core. Port A serves IF, port B serves MEM.

---
 rtl/cpu_spm_be_ctrl_pkg.sv | 31 +++
 rtl/cpu_spm_be_ctrl_dpram.sv | 66 ++++++
 rtl/cpu_spm_be_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_spm_be_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_spm_be_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_spm_be_ctrl_pkg
// Purpose  : Shared definitions for the byte-enable scratch pad memory:
//            default geometry, bus direction/strobe encodings and the
//            clear-engine state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_spm_be_ctrl_pkg;

   // Default geometry
   localparam int c_SPM_DATA_W = 32;
   localparam int c_SPM_ADDR_W = 12;
   localparam int c_SPM_DEPTH  = 4096;

   // Bus direction and active-low strobe encodings
   localparam logic c_READ      = 1'b1;
   localparam logic c_WRITE     = 1'b0;
   localparam logic c_ENABLE_N  = 1'b0;
   localparam logic c_DISABLE_N = 1'b1;

   // Clear-engine state encoding
   localparam int                c_ST_W     = 1;
   localparam logic [c_ST_W-1:0] c_ST_IDLE  = 1'b0;
   localparam logic [c_ST_W-1:0] c_ST_CLEAR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cpu_spm_be_ctrl_dpram.sv
//------------------------------------------------------------------------------
// Module   : cpu_spm_be_ctrl_dpram
// Purpose  : Behavioural dual-port word array with per-byte write enables.
//            Reads are combinational and return the contents before this
//            cycle's writes (read-old-data). Out-of-range addresses read 0
//            and never write.
// Ports    : clk                 system clock
//            i_a_addr/i_b_addr   word address per port
//            i_a_be/i_b_be       byte-lane write enables (0 = no write)
//            i_a_wdata/i_b_wdata write data
//            o_a_rdata/o_b_rdata read data (old contents)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_spm_be_ctrl_dpram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096
)(
   input  logic                  clk,
   input  logic [ADDR_W-1:0]     i_a_addr,
   input  logic [DATA_W/8-1:0]   i_a_be,
   input  logic [DATA_W-1:0]     i_a_wdata,
   output logic [DATA_W-1:0]     o_a_rdata,
   input  logic [ADDR_W-1:0]     i_b_addr,
   input  logic [DATA_W/8-1:0]   i_b_be,
   input  logic [DATA_W-1:0]     i_b_wdata,
   output logic [DATA_W-1:0]     o_b_rdata
);

   localparam int              c_BE_W  = DATA_W / 8;
   localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0]  r_mem [DEPTH];

   logic               w_a_inr;
   logic               w_b_inr;
   logic [c_IDX_W-1:0] w_a_idx;
   logic [c_IDX_W-1:0] w_b_idx;

   assign w_a_inr = ({1'b0, i_a_addr} < c_DEPTH);
   assign w_b_inr = ({1'b0, i_b_addr} < c_DEPTH);
   assign w_a_idx = i_a_addr[c_IDX_W-1:0];
   assign w_b_idx = i_b_addr[c_IDX_W-1:0];

   // The controller guarantees the two ports never enable the same lane of
   // the same word in one cycle, so statement order here is irrelevant.
   always_ff @(posedge clk) begin
      for (int i = 0; i < c_BE_W; i++) begin
         if (w_a_inr && i_a_be[i]) begin
            r_mem[w_a_idx][8*i +: 8] <= i_a_wdata[8*i +: 8];
         end
         if (w_b_inr && i_b_be[i]) begin
            r_mem[w_b_idx][8*i +: 8] <= i_b_wdata[8*i +: 8];
         end
      end
   end

   assign o_a_rdata = w_a_inr ? r_mem[w_a_idx] : '0;
   assign o_b_rdata = w_b_inr ? r_mem[w_b_idx] : '0;

endmodule

`default_nettype wire

// File: rtl/cpu_spm_be_ctrl.sv
//------------------------------------------------------------------------------
// Module   : cpu_spm_be_ctrl
// Purpose  : Dual-port scratch pad memory controller. Port A serves IF,
//            port B serves MEM. Provides byte-enable writes, registered
//            reads with a valid flag, same-address collision merge with
//            cross-port forwarding, and a zero-fill clear engine.
// Ports    : clk, reset_n            clock, asynchronous active-low reset
//            spm_clr / spm_busy      clear request / clear engine running
//            if_spm_*                port A (addr, as_n, rw, be, wr_data,
//                                    rd_data, rd_valid)
//            mem_spm_*               port B (same set as port A)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_spm_be_ctrl
   import cpu_spm_be_ctrl_pkg::*;
#(
   parameter int DATA_W         = c_SPM_DATA_W,
   parameter int ADDR_W         = c_SPM_ADDR_W,
   parameter int DEPTH          = c_SPM_DEPTH,
   parameter bit CLEAR_ON_RESET = 1'b1
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                spm_clr,
   output logic                spm_busy,
   input  logic [ADDR_W-1:0]   if_spm_addr,
   input  logic                if_spm_as_n,
   input  logic                if_spm_rw,
   input  logic [DATA_W/8-1:0] if_spm_be,
   input  logic [DATA_W-1:0]   if_spm_wr_data,
   output logic [DATA_W-1:0]   if_spm_rd_data,
   output logic                if_spm_rd_valid,
   input  logic [ADDR_W-1:0]   mem_spm_addr,
   input  logic                mem_spm_as_n,
   input  logic                mem_spm_rw,
   input  logic [DATA_W/8-1:0] mem_spm_be,
   input  logic [DATA_W-1:0]   mem_spm_wr_data,
   output logic [DATA_W-1:0]   mem_spm_rd_data,
   output logic                mem_spm_rd_valid
);

   localparam int                c_BE_W    = DATA_W / 8;
   localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   c_LAST    = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [c_ST_W-1:0] c_ST_RST  = CLEAR_ON_RESET ? c_ST_CLEAR : c_ST_IDLE;

   //---------------------------------------------------------------------------
   // Clear engine FSM
   //---------------------------------------------------------------------------
   logic [c_ST_W-1:0] r_state;
   logic [c_ST_W-1:0] w_state_nxt;
   // One bit wider than the address so DEPTH == 2**ADDR_W cannot wrap early
   logic [ADDR_W:0]   r_clr_cnt;
   logic [ADDR_W:0]   w_clr_cnt_nxt;
   logic              w_busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= c_ST_RST;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         c_ST_IDLE: begin
            if (spm_clr) begin
               w_state_nxt   = c_ST_CLEAR;
               w_clr_cnt_nxt = '0;
            end
         end
         c_ST_CLEAR: begin
            if (r_clr_cnt == c_LAST) begin
               w_state_nxt   = c_ST_IDLE;
               w_clr_cnt_nxt = '0;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt   = c_ST_IDLE;
            w_clr_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_busy = (r_state == c_ST_CLEAR);
   end

   assign spm_busy = w_busy;

   //---------------------------------------------------------------------------
   // Port decode and collision merge
   //---------------------------------------------------------------------------
   logic              w_a_act, w_a_rd, w_a_wr, w_a_inr;
   logic              w_b_act, w_b_rd, w_b_wr, w_b_inr;
   logic              w_same;
   logic [c_BE_W-1:0] w_a_be_eff;
   logic [c_BE_W-1:0] w_b_be_eff;

   assign w_a_act = !w_busy && (if_spm_as_n == c_ENABLE_N);
   assign w_b_act = !w_busy && (mem_spm_as_n == c_ENABLE_N);
   assign w_a_rd  = w_a_act && (if_spm_rw == c_READ);
   assign w_a_wr  = w_a_act && (if_spm_rw == c_WRITE);
   assign w_b_rd  = w_b_act && (mem_spm_rw == c_READ);
   assign w_b_wr  = w_b_act && (mem_spm_rw == c_WRITE);
   assign w_a_inr = ({1'b0, if_spm_addr} < c_DEPTH);
   assign w_b_inr = ({1'b0, mem_spm_addr} < c_DEPTH);
   assign w_same  = (if_spm_addr == mem_spm_addr);

   // MEM owns every lane it enables; IF keeps only the lanes MEM leaves alone
   // when both hit the same word.
   assign w_b_be_eff = (w_b_wr && w_b_inr) ? mem_spm_be : '0;
   assign w_a_be_eff = (w_a_wr && w_a_inr) ? (if_spm_be & ~(w_same ? w_b_be_eff : '0)) : '0;

   //---------------------------------------------------------------------------
   // Array, port B shared between the clear engine and MEM
   //---------------------------------------------------------------------------
   logic [ADDR_W-1:0] w_ram_b_addr;
   logic [c_BE_W-1:0] w_ram_b_be;
   logic [DATA_W-1:0] w_ram_b_wdata;
   logic [DATA_W-1:0] w_ram_a_rdata;
   logic [DATA_W-1:0] w_ram_b_rdata;

   assign w_ram_b_addr  = w_busy ? r_clr_cnt[ADDR_W-1:0] : mem_spm_addr;
   assign w_ram_b_be    = w_busy ? '1 : w_b_be_eff;
   assign w_ram_b_wdata = w_busy ? '0 : mem_spm_wr_data;

   cpu_spm_be_ctrl_dpram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_dpram (
      .clk       (clk),
      .i_a_addr  (if_spm_addr),
      .i_a_be    (w_a_be_eff),
      .i_a_wdata (if_spm_wr_data),
      .o_a_rdata (w_ram_a_rdata),
      .i_b_addr  (w_ram_b_addr),
      .i_b_be    (w_ram_b_be),
      .i_b_wdata (w_ram_b_wdata),
      .o_b_rdata (w_ram_b_rdata)
   );

   //---------------------------------------------------------------------------
   // Cross-port forwarding: a reader sees the other port's same-cycle write
   //---------------------------------------------------------------------------
   logic [DATA_W-1:0] w_a_rd_nxt;
   logic [DATA_W-1:0] w_b_rd_nxt;

   always_comb begin
      w_a_rd_nxt = w_ram_a_rdata;
      w_b_rd_nxt = w_ram_b_rdata;
      for (int i = 0; i < c_BE_W; i++) begin
         if (w_same && w_b_be_eff[i]) begin
            w_a_rd_nxt[8*i +: 8] = mem_spm_wr_data[8*i +: 8];
         end
         if (w_same && w_a_be_eff[i]) begin
            w_b_rd_nxt[8*i +: 8] = if_spm_wr_data[8*i +: 8];
         end
      end
   end

   //---------------------------------------------------------------------------
   // Registered read outputs; data holds between reads
   //---------------------------------------------------------------------------
   logic [DATA_W-1:0] r_if_rd_data;
   logic              r_if_rd_valid;
   logic [DATA_W-1:0] r_mem_rd_data;
   logic              r_mem_rd_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_if_rd_data   <= '0;
         r_if_rd_valid  <= 1'b0;
         r_mem_rd_data  <= '0;
         r_mem_rd_valid <= 1'b0;
      end else begin
         r_if_rd_valid  <= w_a_rd;
         r_mem_rd_valid <= w_b_rd;
         if (w_a_rd) begin
            r_if_rd_data <= w_a_rd_nxt;
         end
         if (w_b_rd) begin
            r_mem_rd_data <= w_b_rd_nxt;
         end
      end
   end

   assign if_spm_rd_data   = r_if_rd_data;
   assign if_spm_rd_valid  = r_if_rd_valid;
   assign mem_spm_rd_data  = r_mem_rd_data;
   assign mem_spm_rd_valid = r_mem_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_cpu_spm_be_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_cpu_spm_be_ctrl
// Purpose  : Directed self-checking bench for cpu_spm_be_ctrl (DEPTH=16).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_spm_be_ctrl;
   import cpu_spm_be_ctrl_pkg::*;

   localparam int c_DATA_W = 32;
   localparam int c_ADDR_W = 5;
   localparam int c_DEPTH  = 16;
   localparam int c_BE_W   = c_DATA_W / 8;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                spm_clr;
   logic                spm_busy;
   logic [c_ADDR_W-1:0] if_spm_addr;
   logic                if_spm_as_n;
   logic                if_spm_rw;
   logic [c_BE_W-1:0]   if_spm_be;
   logic [c_DATA_W-1:0] if_spm_wr_data;
   logic [c_DATA_W-1:0] if_spm_rd_data;
   logic                if_spm_rd_valid;
   logic [c_ADDR_W-1:0] mem_spm_addr;
   logic                mem_spm_as_n;
   logic                mem_spm_rw;
   logic [c_BE_W-1:0]   mem_spm_be;
   logic [c_DATA_W-1:0] mem_spm_wr_data;
   logic [c_DATA_W-1:0] mem_spm_rd_data;
   logic                mem_spm_rd_valid;

   int n_tests = 0;
   int n_fail  = 0;
   int n_cyc;

   always #5 clk = ~clk;

   cpu_spm_be_ctrl #(
      .DATA_W         (c_DATA_W),
      .ADDR_W         (c_ADDR_W),
      .DEPTH          (c_DEPTH),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .spm_clr          (spm_clr),
      .spm_busy         (spm_busy),
      .if_spm_addr      (if_spm_addr),
      .if_spm_as_n      (if_spm_as_n),
      .if_spm_rw        (if_spm_rw),
      .if_spm_be        (if_spm_be),
      .if_spm_wr_data   (if_spm_wr_data),
      .if_spm_rd_data   (if_spm_rd_data),
      .if_spm_rd_valid  (if_spm_rd_valid),
      .mem_spm_addr     (mem_spm_addr),
      .mem_spm_as_n     (mem_spm_as_n),
      .mem_spm_rw       (mem_spm_rw),
      .mem_spm_be       (mem_spm_be),
      .mem_spm_wr_data  (mem_spm_wr_data),
      .mem_spm_rd_data  (mem_spm_rd_data),
      .mem_spm_rd_valid (mem_spm_rd_valid)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ports();
      spm_clr         = 1'b0;
      if_spm_as_n     = c_DISABLE_N;
      if_spm_rw       = c_READ;
      if_spm_addr     = '0;
      if_spm_be       = '0;
      if_spm_wr_data  = '0;
      mem_spm_as_n    = c_DISABLE_N;
      mem_spm_rw      = c_READ;
      mem_spm_addr    = '0;
      mem_spm_be      = '0;
      mem_spm_wr_data = '0;
   endtask

   task automatic drive_a(input logic rw, input logic [c_ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
      if_spm_as_n    = c_ENABLE_N;
      if_spm_rw      = rw;
      if_spm_addr    = a;
      if_spm_wr_data = d;
      if_spm_be      = be;
   endtask

   task automatic drive_b(input logic rw, input logic [c_ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
      mem_spm_as_n    = c_ENABLE_N;
      mem_spm_rw      = rw;
      mem_spm_addr    = a;
      mem_spm_wr_data = d;
      mem_spm_be      = be;
   endtask

   task automatic wr_a(input logic [c_ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
      drive_a(c_WRITE, a, d, be);
      tick();
      if_spm_as_n = c_DISABLE_N;
   endtask

   task automatic wr_b(input logic [c_ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
      drive_b(c_WRITE, a, d, be);
      tick();
      mem_spm_as_n = c_DISABLE_N;
   endtask

   task automatic rd_a(input string tag, input logic [c_ADDR_W-1:0] a, input logic [31:0] exp);
      drive_a(c_READ, a, 32'h0, 4'h0);
      tick();
      check({tag, "_if_v"}, 32'(if_spm_rd_valid), 32'd1);
      check({tag, "_if_d"}, if_spm_rd_data, exp);
      if_spm_as_n = c_DISABLE_N;
   endtask

   task automatic rd_b(input string tag, input logic [c_ADDR_W-1:0] a, input logic [31:0] exp);
      drive_b(c_READ, a, 32'h0, 4'h0);
      tick();
      check({tag, "_mem_v"}, 32'(mem_spm_rd_valid), 32'd1);
      check({tag, "_mem_d"}, mem_spm_rd_data, exp);
      mem_spm_as_n = c_DISABLE_N;
   endtask

   // Counts cycles until busy falls; any read requested meanwhile must stay invalid.
   task automatic wait_idle(input string tag, output int n);
      n = 0;
      while (spm_busy === 1'b1 && n < 100) begin
         tick();
         n++;
         check({tag, "_if_v"},  32'(if_spm_rd_valid),  32'd0);
         check({tag, "_mem_v"}, 32'(mem_spm_rd_valid), 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values and power-on clear
      reset_n = 1'b0;
      idle_ports();
      repeat (3) tick();
      check("rst_busy",   32'(spm_busy),         32'd1);
      check("rst_if_v",   32'(if_spm_rd_valid),  32'd0);
      check("rst_if_d",   if_spm_rd_data,        32'h0);
      check("rst_mem_v",  32'(mem_spm_rd_valid), 32'd0);
      check("rst_mem_d",  mem_spm_rd_data,       32'h0);
      reset_n = 1'b1;
      drive_a(c_READ, 5'd0, 32'h0, 4'h0);
      drive_b(c_READ, 5'd1, 32'h0, 4'h0);
      wait_idle("por_clr", n_cyc);
      check("por_clr_len", 32'(n_cyc), 32'd16);
      idle_ports();
      for (int a = 0; a < c_DEPTH; a++) begin
         if (a % 2 == 0) rd_a("por_word", 5'(a), 32'h0);
         else            rd_b("por_word", 5'(a), 32'h0);
      end

      // Byte-enable writes
      wr_b(5'd5, 32'hDEADBEEF, 4'b1111);
      wr_b(5'd5, 32'h0000AA00, 4'b0010);
      rd_b("be_merge", 5'd5, 32'hDEADAAEF);
      rd_a("be_merge", 5'd5, 32'hDEADAAEF);
      tick();
      check("idle_if_v", 32'(if_spm_rd_valid), 32'd0);
      check("hold_if_d", if_spm_rd_data, 32'hDEADAAEF);
      wr_a(5'd5, 32'hFFFFFFFF, 4'b0000);
      rd_a("be_zero", 5'd5, 32'hDEADAAEF);

      // Write/write collision: MEM wins on its lanes
      drive_a(c_WRITE, 5'd7, 32'h11223344, 4'b1111);
      drive_b(c_WRITE, 5'd7, 32'hAABBCCDD, 4'b0101);
      tick();
      idle_ports();
      rd_a("ww_same", 5'd7, 32'h11BB33DD);

      // Simultaneous writes to different words do not interact
      drive_a(c_WRITE, 5'd8, 32'h01020304, 4'b1111);
      drive_b(c_WRITE, 5'd9, 32'hA0B0C0D0, 4'b0101);
      tick();
      idle_ports();
      rd_b("ww_diff_a", 5'd8, 32'h01020304);
      rd_b("ww_diff_b", 5'd9, 32'h00B000D0);

      // Forwarding MEM write -> IF read
      drive_b(c_WRITE, 5'd3, 32'hCAFEF00D, 4'b1111);
      drive_a(c_READ,  5'd3, 32'h0, 4'h0);
      tick();
      check("fwd_b2a_v", 32'(if_spm_rd_valid), 32'd1);
      check("fwd_b2a_d", if_spm_rd_data, 32'hCAFEF00D);
      idle_ports();
      rd_b("fwd_b2a_kept", 5'd3, 32'hCAFEF00D);

      // Forwarding partial IF write -> MEM read merges with stored bytes
      wr_b(5'd4, 32'h12345678, 4'b1111);
      drive_a(c_WRITE, 5'd4, 32'h0000BEEF, 4'b0011);
      drive_b(c_READ,  5'd4, 32'h0, 4'h0);
      tick();
      check("fwd_a2b_v", 32'(mem_spm_rd_valid), 32'd1);
      check("fwd_a2b_d", mem_spm_rd_data, 32'h1234BEEF);
      idle_ports();

      // Both ports read the same word
      drive_a(c_READ, 5'd7, 32'h0, 4'h0);
      drive_b(c_READ, 5'd7, 32'h0, 4'h0);
      tick();
      check("rr_if_d",  if_spm_rd_data,  32'h11BB33DD);
      check("rr_mem_d", mem_spm_rd_data, 32'h11BB33DD);
      check("rr_mem_v", 32'(mem_spm_rd_valid), 32'd1);
      idle_ports();

      // Out-of-range: write dropped (no aliasing onto word 4), read returns 0
      wr_b(5'd20, 32'hFFFFFFFF, 4'b1111);
      rd_a("oor_rd", 5'd20, 32'h0);
      rd_b("oor_rd31", 5'd31, 32'h0);
      rd_a("oor_alias", 5'd4, 32'h1234BEEF);

      // Requested clear; MEM write during clear is dropped
      wr_b(5'd2, 32'h12345678, 4'b1111);
      rd_a("pre_clr", 5'd2, 32'h12345678);
      spm_clr = 1'b1;
      tick();
      spm_clr = 1'b0;
      check("clr_busy", 32'(spm_busy), 32'd1);
      wr_b(5'd2, 32'hFFFFFFFF, 4'b1111);
      wait_idle("req_clr", n_cyc);
      check("req_clr_len", 32'(n_cyc + 1), 32'd16);
      rd_a("clr_drop", 5'd2, 32'h0);
      rd_b("clr_all", 5'd7, 32'h0);

      // Reset in the middle of a clear
      wr_b(5'd9, 32'h55AA55AA, 4'b1111);
      rd_a("pre_rst", 5'd9, 32'h55AA55AA);
      rd_b("pre_rst", 5'd9, 32'h55AA55AA);
      spm_clr = 1'b1;
      tick();
      spm_clr = 1'b0;
      repeat (5) tick();
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy",  32'(spm_busy),         32'd1);
      check("mid_rst_if_v",  32'(if_spm_rd_valid),  32'd0);
      check("mid_rst_if_d",  if_spm_rd_data,        32'h0);
      check("mid_rst_mem_d", mem_spm_rd_data,       32'h0);
      drive_a(c_READ, 5'd9, 32'h0, 4'h0);
      drive_b(c_READ, 5'd9, 32'h0, 4'h0);
      repeat (3) begin
         tick();
         check("in_rst_if_v", 32'(if_spm_rd_valid), 32'd0);
         check("in_rst_if_d", if_spm_rd_data, 32'h0);
         check("in_rst_busy", 32'(spm_busy), 32'd1);
      end
      reset_n = 1'b1;
      wait_idle("rst_clr", n_cyc);
      check("rst_clr_len",   32'(n_cyc), 32'd16);
      check("rst_clr_if_d",  if_spm_rd_data,  32'h0);
      check("rst_clr_mem_d", mem_spm_rd_data, 32'h0);
      idle_ports();
      rd_a("rst_cleared", 5'd9, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
